// File: rtl/qadd_share_ctrl_pkg.sv
// Shared types and constants for the shared qadd scheduler.
// Q15 fixed-point, sign-magnitude words.
package qadd_share_ctrl_pkg;

  localparam int QW = 32;
  localparam int SIGN_BIT = QW - 1;
  localparam logic [QW-1:0] Q_ONE = 32'h0000_8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/qadd_share_ctrl_if.sv
// Request/response bundle between requesters and the shared adder.
// master = requester side, slave = scheduler side.
interface qadd_share_ctrl_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  import qadd_share_ctrl_pkg::*;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [N-1:0]      resp_c;
  logic              resp_ovf;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_c,
    input  resp_ovf
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_c,
    output resp_ovf
  );

endinterface

// File: rtl/qadd.sv
// Combinational sign-magnitude fixed-point adder.
// Wraps on magnitude overflow; equal-magnitude cancellation gives +0.
module qadd #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c
);

  if (Q < 0 || Q > N - 2) begin : g_q_range
    $error("qadd: Q out of range");
  end

  always_comb begin
    c = '0;
    if (a[N-1] == b[N-1]) begin
      c[N-2:0] = a[N-2:0] + b[N-2:0];
      c[N-1]   = a[N-1];
    end else if (a[N-2:0] > b[N-2:0]) begin
      c[N-2:0] = a[N-2:0] - b[N-2:0];
      c[N-1]   = a[N-1];
    end else begin
      c[N-2:0] = b[N-2:0] - a[N-2:0];
      c[N-1]   = b[N-1] & (b[N-2:0] != a[N-2:0]);
    end
  end

endmodule

// File: rtl/qadd_share_ctrl_rr_arbiter.sv
// Round-robin grant: first requester at or above ptr_i, wrapping.
// Output is one-hot or zero.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qadd_share_ctrl.sv
// Round-robin scheduler sharing one qadd among NREQ requesters.
// Operands and sum are registered; one op in flight at a time.
module qadd_share_ctrl
  import qadd_share_ctrl_pkg::*;
#(
  parameter int Q    = 15,
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  qadd_share_ctrl_if.slave bus,
  output logic             busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   id_q, id_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    res_q, res_d;
  logic            ovf_q, ovf_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_id;
  logic [NREQ-1:0] id_oh;
  logic            take;
  logic [N-1:0]    sum;
  logic [N-1:0]    mag_sum;
  logic            ovf;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  qadd #(.Q(Q), .N(N)) u_qadd (
    .a (a_q),
    .b (b_q),
    .c (sum)
  );

  // carry out of the magnitude field, only meaningful on same-sign adds
  assign mag_sum = {1'b0, a_q[N-2:0]} + {1'b0, b_q[N-2:0]};
  assign ovf     = (a_q[N-1] == b_q[N-1]) & |(mag_sum >> (N - 1));

  assign take = (state_q == IDLE) & |gnt;

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) gnt_id = PW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          id_d    = gnt_id;
          a_d     = bus.req_a[int'(gnt_id)*N +: N];
          b_d     = bus.req_b[int'(gnt_id)*N +: N];
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = sum;
        ovf_d   = ovf;
        state_d = DONE;
      end
      DONE: begin
        if (bus.resp_ready[id_q]) begin
          state_d = IDLE;
          if (int'(id_q) == NREQ - 1) rr_ptr_d = '0;
          else rr_ptr_d = id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    id_oh        = '0;
    id_oh[id_q]  = 1'b1;
    bus.req_ready  = (state_q == IDLE) ? gnt : '0;
    bus.resp_valid = (state_q == DONE) ? id_oh : '0;
    busy           = (state_q != IDLE);
  end

  assign bus.resp_c   = res_q;
  assign bus.resp_ovf = ovf_q;

endmodule
